pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Hazard and pipeline-control unit for the 5-stage vector ASIP pipeline (IF/ID/EX/MEM/WB).
- Drives the enable (stall) and flush inputs of the IF/ID, ID/EX and EX/MEM pipeline registers.
- Consumes the register addresses and control bits those registers emit, and produces operand-forwarding selects for EX.
- Sequences multi-cycle vector memory accesses and post-jump flushes with a small FSM, and keeps a saturating stall counter.

Parameters:
- REG_W, 4, register-address width
- FLUSH_CYCLES, 2, cycles flushD is held after a taken jump (>=1)
- MEM_TIMEOUT, 64, wait cycles on mem_ack before memErr is set
- CNT_W, 16, stall-counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- R2d, R3d  in  REG_W  source registers of the instruction in ID
- useR2d, useR3d  in  1  ID instruction reads R2d / R3d
- R2e, R3e  in  REG_W  source registers of the instruction in EX
- DestRe  in  REG_W  EX destination
- wrege, rmeme  in  1  EX writes a register / is a load
- DestRm  in  REG_W  MEM destination
- wregm  in  1  MEM writes a register
- DestRw  in  REG_W  WB destination
- wregw  in  1  WB writes a register
- jmpTaken  in  1  branch resolved taken in EX (single-cycle pulse)
- memReq  in  1  MEM stage starts a vector memory access
- memAck  in  1  memory completes the access
- stallF, stallD, stallE, stallM  out  1  hold PC / IF-ID / ID-EX / EX-MEM
- flushD, flushE  out  1  clear IF-ID / ID-EX on the next edge
- fwdA, fwdB  out  2  EX operand select for R2e / R3e: 00 = regfile, 01 = MEM result, 10 = WB result
- memErr  out  1  sticky memory-timeout flag
- stallCnt  out  CNT_W  saturating count of cycles with stallF=1

Behaviour:
- Reset: state=RUN, counters=0, memErr=0.
  - Combinational outputs evaluate from reset state and inputs; fwdA/fwdB still reflect inputs.
  - Reset takes effect mid-wait or mid-flush with no residue.
- Forwarding (combinational, all states):
  - fwdA=01 if wregm && DestRm==R2e.
  - Else fwdA=10 if wregw && DestRw==R2e.
  - Else 00.
  - MEM has priority over WB. fwdB uses R3e by the same rules. No register is hardwired; R0 is forwardable.
- Load-use hazard, loadUse: rmeme && wrege && ((useR2d && DestRe==R2d) || (useR3d && DestRe==R3d)).
- States: RUN, MEMWAIT, FLUSH.
- RUN, priority order:
  1. memReq && !memAck: stallF, stallD, stallE and stallM = 1 this cycle; next state MEMWAIT; waitCnt<=1.
  2. memReq && memAck in the same cycle means a zero-wait access: no stall, stay RUN.
  3. jmpTaken: flushD=1, flushE=1 this cycle. If FLUSH_CYCLES>1, next state FLUSH with flCnt<=FLUSH_CYCLES-1; else stay RUN.
  4. loadUse: stallF=1, stallD=1, flushE=1 for exactly one cycle (bubble); stay RUN.
  5. Otherwise all stall/flush outputs = 0.
- MEMWAIT:
  - All four stalls = 1; no flushes, even if jmpTaken (EX is frozen, so jmpTaken is ignored).
  - memAck=1: stalls still =1 this cycle, next state RUN; the following cycle is the first unstalled cycle.
  - Otherwise waitCnt++. When waitCnt reaches MEM_TIMEOUT, memErr<=1 (sticky until rst) and next state RUN (abandon).
- FLUSH:
  - flushD=1 and stallF=0 (PC loads jump target).
  - flCnt--; exit to RUN when flCnt reaches 0 after this cycle.
  - A new jmpTaken here also asserts flushE and reloads flCnt<=FLUSH_CYCLES-1.
  - loadUse is ignored (ID holds a flushed bubble).
- stallCnt increments when stallF=1, saturates at all-ones, and clears only on rst.
- Latency: all hazard responses are same-cycle combinational from inputs and state; state updates take one cycle.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - typedef enum logic[1:0] {RUN, MEMWAIT, FLUSH} hz_state_t;
  - fwd-select constants FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
  - REG_W default.
- One sub-module, fwd_unit (pure combinational, instantiated once for each of A and B), computes a single 2-bit select from a source address and the MEM/WB destinations.

Test Plan:
- R2e=3, wregm=1, DestRm=3, wregw=1, DestRw=3 -> fwdA=01. With wregm=0 -> fwdA=10. R3e=5 unmatched -> fwdB=00.
- EX load (rmeme=1, wrege=1, DestRe=7), ID useR2d=1, R2d=7 -> stallF=stallD=flushE=1 for exactly 1 cycle, stallCnt=1. Same case with useR2d=0 -> no stall.
- memReq=1, memAck held 0 for 4 cycles then 1 -> stallM=1 for 5 cycles, back to RUN next cycle, stallCnt=5, memErr=0.
- memReq=1, memAck never asserted (MEM_TIMEOUT=64) -> memErr=1 after 64 cycles, stays 1 until rst, FSM returns to RUN.
- jmpTaken pulse with FLUSH_CYCLES=2 -> cycle0 flushD=flushE=1, cycle1 flushD=1 only, cycle2 all 0. Second jmpTaken in cycle1 extends flushD by 1 cycle.
- rst=1 asserted in MEMWAIT at waitCnt=10 -> next cycle state RUN, stalls 0 (memReq=0), stallCnt=0, memErr=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/control unit.
package pipe_ctrl_pkg;

    localparam int unsigned REG_W_DFLT = 4;
    localparam int unsigned CNT_W_DFLT = 16;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic [1:0] {RUN, MEMWAIT, FLUSH} hz_state_t;

    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
    } hz_ctrl_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline <-> hazard unit signal bundle; master is the datapath, slave the hazard unit.
interface pipeline_hazard_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_W = REG_W_DFLT,
    parameter int unsigned CNT_W = CNT_W_DFLT
);
    logic [REG_W-1:0] R2d, R3d;
    logic             useR2d, useR3d;
    logic [REG_W-1:0] R2e, R3e, DestRe;
    logic             wrege, rmeme;
    logic [REG_W-1:0] DestRm;
    logic             wregm;
    logic [REG_W-1:0] DestRw;
    logic             wregw;
    logic             jmpTaken, memReq, memAck;

    logic             stallF, stallD, stallE, stallM;
    logic             flushD, flushE;
    logic [1:0]       fwdA, fwdB;
    logic             memErr;
    logic [CNT_W-1:0] stallCnt;

    modport master (
        output R2d, R3d, useR2d, useR3d, R2e, R3e, DestRe, wrege, rmeme,
               DestRm, wregm, DestRw, wregw, jmpTaken, memReq, memAck,
        input  stallF, stallD, stallE, stallM, flushD, flushE,
               fwdA, fwdB, memErr, stallCnt
    );

    modport slave (
        input  R2d, R3d, useR2d, useR3d, R2e, R3e, DestRe, wrege, rmeme,
               DestRm, wregm, DestRw, wregw, jmpTaken, memReq, memAck,
        output stallF, stallD, stallE, stallM, flushD, flushE,
               fwdA, fwdB, memErr, stallCnt
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_fwd.sv
// Operand-forwarding select for one EX source; the MEM result wins over WB.
module fwd_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_W = REG_W_DFLT
) (
    input  logic [REG_W-1:0] src_i,
    input  logic [REG_W-1:0] dest_m_i,
    input  logic             wreg_m_i,
    input  logic [REG_W-1:0] dest_w_i,
    input  logic             wreg_w_i,
    output logic [1:0]       sel_c_o
);

    always_comb begin
        sel_c_o = FWD_RF;
        if (wreg_m_i && (dest_m_i == src_i)) begin
            sel_c_o = FWD_MEM;
        end else if (wreg_w_i && (dest_w_i == src_i)) begin
            sel_c_o = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and pipeline-control unit: forwarding, load-use bubbles, memory-wait
// stalls, post-jump flushes and a saturating stall counter.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_W        = REG_W_DFLT,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT  = 64,
    parameter int unsigned CNT_W        = CNT_W_DFLT
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_hazard_ctrl_if.slave  bus_io
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam int unsigned FL_W   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
    localparam logic [FL_W-1:0]   FL_RELOAD = FL_W'(FLUSH_CYCLES - 1);

    hz_state_t         state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [FL_W-1:0]   fl_q, fl_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    hz_ctrl_t          ctrl_c;
    logic              load_use_c;

    fwd_unit #(.REG_W(REG_W)) u_fwd_a (
        .src_i    (bus_io.R2e),
        .dest_m_i (bus_io.DestRm),
        .wreg_m_i (bus_io.wregm),
        .dest_w_i (bus_io.DestRw),
        .wreg_w_i (bus_io.wregw),
        .sel_c_o  (bus_io.fwdA)
    );

    fwd_unit #(.REG_W(REG_W)) u_fwd_b (
        .src_i    (bus_io.R3e),
        .dest_m_i (bus_io.DestRm),
        .wreg_m_i (bus_io.wregm),
        .dest_w_i (bus_io.DestRw),
        .wreg_w_i (bus_io.wregw),
        .sel_c_o  (bus_io.fwdB)
    );

    assign load_use_c = bus_io.rmeme && bus_io.wrege &&
                        ((bus_io.useR2d && (bus_io.DestRe == bus_io.R2d)) ||
                         (bus_io.useR3d && (bus_io.DestRe == bus_io.R3d)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wait_q      <= '0;
            fl_q        <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            fl_q        <= fl_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next-state and same-cycle stall/flush decode
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        fl_d    = fl_q;
        err_d   = err_q;
        ctrl_c  = '0;
        unique case (state_q)
            RUN: begin
                if (bus_io.memReq && !bus_io.memAck) begin
                    ctrl_c  = '{stall_f: 1'b1, stall_d: 1'b1, stall_e: 1'b1,
                                stall_m: 1'b1, flush_d: 1'b0, flush_e: 1'b0};
                    state_d = MEMWAIT;
                    wait_d  = WAIT_W'(1);
                end else if (bus_io.memReq) begin
                    // zero-wait access outranks jump and load-use handling
                    state_d = RUN;
                end else if (bus_io.jmpTaken) begin
                    ctrl_c.flush_d = 1'b1;
                    ctrl_c.flush_e = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = FLUSH;
                        fl_d    = FL_RELOAD;
                    end
                end else if (load_use_c) begin
                    ctrl_c.stall_f = 1'b1;
                    ctrl_c.stall_d = 1'b1;
                    ctrl_c.flush_e = 1'b1;
                end
            end
            MEMWAIT: begin
                ctrl_c = '{stall_f: 1'b1, stall_d: 1'b1, stall_e: 1'b1,
                           stall_m: 1'b1, flush_d: 1'b0, flush_e: 1'b0};
                if (bus_io.memAck) begin
                    state_d = RUN;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                    if (wait_d == WAIT_MAX) begin
                        err_d   = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            FLUSH: begin
                ctrl_c.flush_d = 1'b1;
                if (bus_io.jmpTaken) begin
                    ctrl_c.flush_e = 1'b1;
                    fl_d           = FL_RELOAD;
                end else begin
                    fl_d = fl_q - FL_W'(1);
                    if (fl_d == '0) begin
                        state_d = RUN;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (ctrl_c.stall_f && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    assign bus_io.stallF   = ctrl_c.stall_f;
    assign bus_io.stallD   = ctrl_c.stall_d;
    assign bus_io.stallE   = ctrl_c.stall_e;
    assign bus_io.stallM   = ctrl_c.stall_m;
    assign bus_io.flushD   = ctrl_c.flush_d;
    assign bus_io.flushE   = ctrl_c.flush_e;
    assign bus_io.memErr   = err_q;
    assign bus_io.stallCnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a queue-based scoreboard.
module tb_pipeline_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int unsigned CNT_W = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.REG_W(4), .CNT_W(CNT_W)) bus ();

    pipeline_hazard_ctrl #(
        .REG_W(4), .FLUSH_CYCLES(2), .MEM_TIMEOUT(64), .CNT_W(CNT_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus.slave)
    );

    typedef struct {
        string       tag;
        logic [26:0] val;
    } exp_t;

    exp_t             sb_q[$];
    int               n_cmp = 0;
    int               n_err = 0;
    logic [CNT_W-1:0] m_cnt;
    logic             m_err;

    task automatic idle();
        bus.R2d = '0; bus.R3d = '0; bus.useR2d = 1'b0; bus.useR3d = 1'b0;
        bus.R2e = '0; bus.R3e = '0; bus.DestRe = '0;
        bus.wrege = 1'b0; bus.rmeme = 1'b0;
        bus.DestRm = '0; bus.wregm = 1'b0;
        bus.DestRw = '0; bus.wregw = 1'b0;
        bus.jmpTaken = 1'b0; bus.memReq = 1'b0; bus.memAck = 1'b0;
    endtask

    // st = {stallF,stallD,stallE,stallM}, fl = {flushD,flushE}
    task automatic step(input string tag, input logic [3:0] st, input logic [1:0] fl,
                        input logic [1:0] fa, input logic [1:0] fb);
        exp_t        e;
        logic [26:0] obs;
        e.tag = tag;
        e.val = {st, fl, fa, fb, m_err, m_cnt};
        sb_q.push_back(e);
        #1;
        e   = sb_q.pop_front();
        obs = {bus.stallF, bus.stallD, bus.stallE, bus.stallM, bus.flushD, bus.flushE,
               bus.fwdA, bus.fwdB, bus.memErr, bus.stallCnt};
        n_cmp++;
        assert (obs === e.val)
        else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h (st,fl,fa,fb,err,cnt)", e.tag, obs, e.val);
        end
        if (st[3] && (m_cnt != '1)) m_cnt = m_cnt + CNT_W'(1);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        m_cnt = '0;
        m_err = 1'b0;

        step("reset_state", 4'b0000, 2'b00, FWD_RF, FWD_RF);

        // forwarding
        bus.R2e = 4'd3; bus.R3e = 4'd5;
        bus.wregm = 1'b1; bus.DestRm = 4'd3; bus.wregw = 1'b1; bus.DestRw = 4'd3;
        step("fwd_mem_priority", 4'b0000, 2'b00, FWD_MEM, FWD_RF);
        bus.wregm = 1'b0;
        step("fwd_wb_only", 4'b0000, 2'b00, FWD_WB, FWD_RF);
        bus.R2e = 4'd9; bus.R3e = 4'd3; bus.wregm = 1'b1; bus.DestRw = 4'd9;
        step("fwd_split", 4'b0000, 2'b00, FWD_WB, FWD_MEM);
        bus.R2e = 4'd0; bus.R3e = 4'd0; bus.DestRm = 4'd0; bus.wregm = 1'b0; bus.DestRw = 4'd0;
        step("fwd_r0_wb", 4'b0000, 2'b00, FWD_WB, FWD_WB);
        bus.wregm = 1'b1; bus.wregw = 1'b0; bus.R3e = 4'd1;
        step("fwd_r0_mem", 4'b0000, 2'b00, FWD_MEM, FWD_RF);

        // load-use bubble
        idle();
        bus.rmeme = 1'b1; bus.wrege = 1'b1; bus.DestRe = 4'd7; bus.useR2d = 1'b1; bus.R2d = 4'd7;
        step("load_use_r2", 4'b1100, 2'b01, FWD_RF, FWD_RF);
        idle();
        step("after_bubble", 4'b0000, 2'b00, FWD_RF, FWD_RF);
        bus.rmeme = 1'b1; bus.wrege = 1'b1; bus.DestRe = 4'd7; bus.R2d = 4'd7;
        step("load_no_use", 4'b0000, 2'b00, FWD_RF, FWD_RF);
        bus.rmeme = 1'b0; bus.useR3d = 1'b1; bus.R3d = 4'd7;
        step("not_a_load", 4'b0000, 2'b00, FWD_RF, FWD_RF);
        bus.rmeme = 1'b1;
        step("load_use_r3", 4'b1100, 2'b01, FWD_RF, FWD_RF);

        // memory wait with four cycles of no ack
        idle();
        bus.memReq = 1'b1;
        step("mem_wait0", 4'b1111, 2'b00, FWD_RF, FWD_RF);
        step("mem_wait1", 4'b1111, 2'b00, FWD_RF, FWD_RF);
        bus.jmpTaken = 1'b1;
        step("mem_wait_jmp_ignored", 4'b1111, 2'b00, FWD_RF, FWD_RF);
        bus.jmpTaken = 1'b0;
        step("mem_wait3", 4'b1111, 2'b00, FWD_RF, FWD_RF);
        bus.memAck = 1'b1;
        step("mem_ack", 4'b1111, 2'b00, FWD_RF, FWD_RF);
        idle();
        step("mem_done", 4'b0000, 2'b00, FWD_RF, FWD_RF);
        bus.memReq = 1'b1; bus.memAck = 1'b1;
        step("mem_zero_wait", 4'b0000, 2'b00, FWD_RF, FWD_RF);
        idle();
        step("mem_zero_after", 4'b0000, 2'b00, FWD_RF, FWD_RF);

        // jump flush sequences
        bus.jmpTaken = 1'b1;
        step("jmp_c0", 4'b0000, 2'b11, FWD_RF, FWD_RF);
        idle();
        step("jmp_c1", 4'b0000, 2'b10, FWD_RF, FWD_RF);
        step("jmp_c2", 4'b0000, 2'b00, FWD_RF, FWD_RF);
        bus.jmpTaken = 1'b1;
        step("jmp2_c0", 4'b0000, 2'b11, FWD_RF, FWD_RF);
        step("jmp2_c1_rejmp", 4'b0000, 2'b11, FWD_RF, FWD_RF);
        idle();
        step("jmp2_c2", 4'b0000, 2'b10, FWD_RF, FWD_RF);
        step("jmp2_c3", 4'b0000, 2'b00, FWD_RF, FWD_RF);
        bus.jmpTaken = 1'b1;
        step("jmp3_c0", 4'b0000, 2'b11, FWD_RF, FWD_RF);
        idle();
        bus.rmeme = 1'b1; bus.wrege = 1'b1; bus.DestRe = 4'd2; bus.useR2d = 1'b1; bus.R2d = 4'd2;
        step("flush_ignores_load_use", 4'b0000, 2'b10, FWD_RF, FWD_RF);
        idle();
        step("jmp3_c2", 4'b0000, 2'b00, FWD_RF, FWD_RF);

        // memory timeout
        bus.memReq = 1'b1;
        for (int i = 0; i < 64; i++) begin
            step("timeout_wait", 4'b1111, 2'b00, FWD_RF, FWD_RF);
        end
        m_err = 1'b1;
        idle();
        step("timeout_run", 4'b0000, 2'b00, FWD_RF, FWD_RF);
        step("timeout_sticky", 4'b0000, 2'b00, FWD_RF, FWD_RF);

        // synchronous reset in the middle of a wait
        bus.memReq = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step("pre_rst_wait", 4'b1111, 2'b00, FWD_RF, FWD_RF);
        end
        idle();
        rst = 1'b1;
        step("rst_in_wait", 4'b1111, 2'b00, FWD_RF, FWD_RF);
        m_cnt = '0;
        m_err = 1'b0;
        bus.R2e = 4'd2; bus.wregw = 1'b1; bus.DestRw = 4'd2;
        step("fwd_during_rst", 4'b0000, 2'b00, FWD_WB, FWD_RF);
        rst = 1'b0;
        idle();
        step("post_rst", 4'b0000, 2'b00, FWD_RF, FWD_RF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
